// File: rtl/controlpack.sv
// Shared ALU-side types: op encoding, flag register layout, sequencer states.
// Also holds the op-class decode used by the sequencer.
package controlpack;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        AND = 4'd3,
        OR  = 4'd4,
        XOR = 4'd5,
        THR = 4'd6,
        SHL = 4'd7,
        ROL = 4'd8,
        SHR = 4'd9,
        ROR = 4'd10,
        NOT = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
    } alu_flag_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        RESP   = 3'd4
    } seq_state_e;

    function automatic logic is_binary_op(input alu_op_e op);
        return op inside {ADD, SUB, AND, OR, XOR};
    endfunction

    function automatic logic is_unary_op(input alu_op_e op);
        return op inside {THR, SHL, ROL, SHR, ROR, NOT};
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: result and carry/zero from op and two operands.
// Latency: zero cycles. Backpressure: none, purely combinational.
// Carry is the adder carry-out, subtract borrow, or the bit shifted out; rotates clear it.
module alu
    import controlpack::*;
#(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  alu_op_e                   op,
    input  logic [DATA_BUS_WIDTH-1:0] reg1,
    input  logic [DATA_BUS_WIDTH-1:0] reg2,
    output logic [DATA_BUS_WIDTH-1:0] result,
    output alu_flag_t                 flag
);

    logic [DATA_BUS_WIDTH:0] wide;

    always_comb begin
        wide       = '0;
        result     = '0;
        flag.carry = 1'b0;
        case (op)
            ADD: begin
                wide       = {1'b0, reg1} + {1'b0, reg2};
                result     = wide[DATA_BUS_WIDTH-1:0];
                flag.carry = wide[DATA_BUS_WIDTH];
            end
            SUB: begin
                wide       = {1'b0, reg1} - {1'b0, reg2};
                result     = wide[DATA_BUS_WIDTH-1:0];
                flag.carry = wide[DATA_BUS_WIDTH];
            end
            AND: result = reg1 & reg2;
            OR:  result = reg1 | reg2;
            XOR: result = reg1 ^ reg2;
            THR: result = reg1;
            NOT: result = ~reg1;
            SHL: begin
                result     = {reg1[DATA_BUS_WIDTH-2:0], 1'b0};
                flag.carry = reg1[DATA_BUS_WIDTH-1];
            end
            SHR: begin
                result     = {1'b0, reg1[DATA_BUS_WIDTH-1:1]};
                flag.carry = reg1[0];
            end
            ROL: result = {reg1[DATA_BUS_WIDTH-2:0], reg1[DATA_BUS_WIDTH-1]};
            ROR: result = {reg1[0], reg1[DATA_BUS_WIDTH-1:1]};
            default: result = '0;
        endcase
        flag.zero = (result == '0);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Collects operands for one ALU op, runs it for one cycle, returns result and keeps the flag register.
// Latency: NOP 1 cycle, unary 3, binary 4 from request to rsp_valid.
// Backpressure: holds in LOAD_A/LOAD_B until bus_in_valid and in RESP until rsp_ready; req_ready only in IDLE.
module alu_sequencer
    import controlpack::*;
#(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  alu_op_e                   req_op,
    input  logic [DATA_BUS_WIDTH-1:0] bus_in,
    input  logic                      bus_in_valid,
    output logic                      bus_in_ready,
    output alu_op_e                   alu_op,
    output logic [DATA_BUS_WIDTH-1:0] alu_reg1,
    output logic [DATA_BUS_WIDTH-1:0] alu_reg2,
    input  logic [DATA_BUS_WIDTH-1:0] alu_result,
    input  alu_flag_t                 alu_flag,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_BUS_WIDTH-1:0] rsp_result,
    output alu_flag_t                 flags
);

    seq_state_e                state;
    alu_op_e                   op_q;
    logic [DATA_BUS_WIDTH-1:0] a_q;
    logic [DATA_BUS_WIDTH-1:0] b_q;
    logic [DATA_BUS_WIDTH-1:0] result_q;
    alu_flag_t                 flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= NOP;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flag_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        b_q  <= '0;
                        // Unlisted encodings fall through the NOP path.
                        if (is_binary_op(req_op) || is_unary_op(req_op)) begin
                            state <= LOAD_A;
                        end else begin
                            result_q <= '0;
                            state    <= RESP;
                        end
                    end
                end
                LOAD_A: begin
                    if (bus_in_valid) begin
                        a_q   <= bus_in;
                        state <= is_binary_op(op_q) ? LOAD_B : EXEC;
                    end
                end
                LOAD_B: begin
                    if (bus_in_valid) begin
                        b_q   <= bus_in;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_result;
                    flag_q   <= alu_flag;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state == IDLE);
    assign bus_in_ready = (state == LOAD_A) || (state == LOAD_B);
    assign rsp_valid    = (state == RESP);
    assign alu_op       = (state == EXEC) ? op_q : NOP;
    assign alu_reg1     = a_q;
    assign alu_reg2     = b_q;
    assign rsp_result   = result_q;
    assign flags        = flag_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer wired to alu; each task checks one scenario.
module tb_alu_sequencer;
    import controlpack::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    alu_op_e    req_op = NOP;
    logic [7:0] bus_in = 8'h00;
    logic       bus_in_valid = 1'b0;
    logic       bus_in_ready;
    alu_op_e    alu_op;
    logic [7:0] alu_reg1, alu_reg2, alu_result;
    alu_flag_t  alu_flag;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    alu_flag_t  flags;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_BUS_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .bus_in(bus_in), .bus_in_valid(bus_in_valid), .bus_in_ready(bus_in_ready),
        .alu_op(alu_op), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .flags(flags)
    );

    alu #(.DATA_BUS_WIDTH(8)) u_alu (
        .op(alu_op), .reg1(alu_reg1), .reg2(alu_reg2),
        .result(alu_result), .flag(alu_flag)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, feeds operands (first one after `delay` ready cycles), stops at rsp_valid.
    task automatic issue(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                         input int delay, output int lat, output int used,
                         output int execs, output int op_bad);
        int waited = 0;
        lat = 0; used = 0; execs = 0; op_bad = 0;
        req_op = op;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            if (alu_op !== NOP) begin
                execs++;
                if (alu_op !== op) op_bad++;
            end
            bus_in_valid = 1'b0;
            if (bus_in_ready) begin
                if (waited < delay) waited++;
                else begin
                    bus_in_valid = 1'b1;
                    bus_in = (used == 0) ? a : b;
                end
            end
            step();
            if (bus_in_valid) used++;
            bus_in_valid = 1'b0;
            lat++;
        end
        if (alu_op !== NOP) op_bad++;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_rsp: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || bus_in_ready !== 1'b0 || alu_op !== NOP) begin
            bad++;
            $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b bus_in_ready=%b alu_op=%0d want 1/0/0/0",
                     req_ready, rsp_valid, bus_in_ready, alu_op);
        end
        total++;
        if (flags !== 2'b00 || alu_reg1 !== 8'h00 || alu_reg2 !== 8'h00 || rsp_result !== 8'h00) begin
            bad++;
            $display("FAIL reset_regs: flags=%b reg1=%h reg2=%h result=%h want all zero",
                     flags, alu_reg1, alu_reg2, rsp_result);
        end
    endtask

    task automatic test_add();
        int lat, used, execs, op_bad;
        issue(ADD, 8'hF0, 8'h20, 0, lat, used, execs, op_bad);
        total++;
        if (lat !== 4 || used !== 2 || execs !== 1 || op_bad !== 0) begin
            bad++;
            $display("FAIL add_timing: lat=%0d used=%0d execs=%0d op_bad=%0d want 4/2/1/0", lat, used, execs, op_bad);
        end
        total++;
        if (rsp_result !== 8'h10 || flags.carry !== 1'b1 || flags.zero !== 1'b0) begin
            bad++;
            $display("FAIL add_result: result=%h c=%b z=%b want 10/1/0", rsp_result, flags.carry, flags.zero);
        end
        finish_rsp();
    endtask

    task automatic test_sub_nop();
        int lat, used, execs, op_bad;
        issue(SUB, 8'h05, 8'h05, 0, lat, used, execs, op_bad);
        total++;
        if (lat !== 4 || rsp_result !== 8'h00 || flags.zero !== 1'b1 || flags.carry !== 1'b0) begin
            bad++;
            $display("FAIL sub_result: lat=%0d result=%h c=%b z=%b want 4/00/0/1", lat, rsp_result, flags.carry, flags.zero);
        end
        finish_rsp();
        issue(NOP, 8'h77, 8'h77, 0, lat, used, execs, op_bad);
        total++;
        if (lat !== 1 || used !== 0 || execs !== 0 || rsp_result !== 8'h00 || flags !== 2'b01) begin
            bad++;
            $display("FAIL nop_after_sub: lat=%0d used=%0d execs=%0d result=%h flags=%b want 1/0/0/00/01",
                     lat, used, execs, rsp_result, flags);
        end
        finish_rsp();
    endtask

    task automatic test_shr_delay();
        int lat, used, execs, op_bad;
        issue(SHR, 8'h01, 8'hEE, 3, lat, used, execs, op_bad);
        total++;
        if (lat !== 6 || used !== 1 || execs !== 1 || op_bad !== 0) begin
            bad++;
            $display("FAIL shr_timing: lat=%0d used=%0d execs=%0d op_bad=%0d want 6/1/1/0", lat, used, execs, op_bad);
        end
        total++;
        if (rsp_result !== 8'h00 || flags.carry !== 1'b1 || flags.zero !== 1'b1 || alu_reg2 !== 8'h00) begin
            bad++;
            $display("FAIL shr_result: result=%h c=%b z=%b reg2=%h want 00/1/1/00",
                     rsp_result, flags.carry, flags.zero, alu_reg2);
        end
        finish_rsp();
    endtask

    task automatic test_xor_stall();
        int lat, used, execs, op_bad;
        int stall_bad = 0;
        issue(XOR, 8'hAA, 8'h55, 0, lat, used, execs, op_bad);
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== 8'hFF || flags !== 2'b00) stall_bad++;
            req_valid = 1'b1;
            req_op = ADD;
            step();
        end
        req_valid = 1'b0;
        total++;
        if (lat !== 4 || stall_bad !== 0) begin
            bad++;
            $display("FAIL xor_stall: lat=%0d bad_cycles=%0d want 4/0", lat, stall_bad);
        end
        finish_rsp();
        step();
        total++;
        if (req_ready !== 1'b1 || bus_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL xor_req_ignored: req_ready=%b bus_in_ready=%b want 1/0", req_ready, bus_in_ready);
        end
        issue(NOP, 8'h00, 8'h00, 0, lat, used, execs, op_bad);
        total++;
        if (lat !== 1 || rsp_result !== 8'h00 || flags !== 2'b00) begin
            bad++;
            $display("FAIL nop_after_xor: lat=%0d result=%h flags=%b want 1/00/00", lat, rsp_result, flags);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        int lat, used, execs, op_bad;
        issue(ROL, 8'h81, 8'h00, 0, lat, used, execs, op_bad);
        total++;
        if (lat !== 3 || used !== 1 || rsp_result !== 8'h03 || flags.carry !== 1'b0 || flags.zero !== 1'b0) begin
            bad++;
            $display("FAIL rol_result: lat=%0d used=%0d result=%h c=%b z=%b want 3/1/03/0/0",
                     lat, used, rsp_result, flags.carry, flags.zero);
        end
        finish_rsp();
        issue(THR, 8'h00, 8'h00, 0, lat, used, execs, op_bad);
        total++;
        if (lat !== 3 || rsp_result !== 8'h00 || flags.zero !== 1'b1 || flags.carry !== 1'b0) begin
            bad++;
            $display("FAIL thr_result: lat=%0d result=%h c=%b z=%b want 3/00/0/1", lat, rsp_result, flags.carry, flags.zero);
        end
        finish_rsp();
    endtask

    task automatic test_rst_abort();
        int rsp_seen = 0;
        req_op = ADD;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        bus_in = 8'h33;
        bus_in_valid = 1'b1;
        step();
        bus_in_valid = 1'b0;
        total++;
        if (alu_reg1 !== 8'h33 || bus_in_ready !== 1'b1 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_load_b: reg1=%h bus_in_ready=%b req_ready=%b want 33/1/0", alu_reg1, bus_in_ready, req_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (req_ready !== 1'b1 || flags !== 2'b00 || alu_reg1 !== 8'h00 || rsp_valid !== 1'b0 || bus_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: req_ready=%b flags=%b reg1=%h rsp_valid=%b bus_in_ready=%b want 1/00/00/0/0",
                     req_ready, flags, alu_reg1, rsp_valid, bus_in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b0) rsp_seen++;
            step();
        end
        total++;
        if (rsp_seen !== 0) begin
            bad++;
            $display("FAIL abort_no_rsp: rsp_valid cycles=%0d want 0", rsp_seen);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_nop();
        test_shr_delay();
        test_xor_stall();
        test_back_to_back();
        test_rst_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the ALU interface: a multi-cycle controller that accepts an operation request and collects operands from the data bus over a valid/ready handshake.
- It drives op/register1/register2 into the combinational alu, then captures the result and flags into registers.
- It returns the result over a response handshake.
- Sits between the control unit and the alu; holds the architectural flag register.

Parameters:
- DATA_BUS_WIDTH, 8, width of operands, result and bus.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  operation request valid
- req_ready  out  1  sequencer can accept request (IDLE only)
- req_op  in  alu_op_e  requested operation
- bus_in  in  DATA_BUS_WIDTH  operand data
- bus_in_valid  in  1  operand on bus_in valid
- bus_in_ready  out  1  sequencer is consuming an operand
- alu_op  out  alu_op_e  op to alu; NOP outside EXEC
- alu_reg1  out  DATA_BUS_WIDTH  operand A register
- alu_reg2  out  DATA_BUS_WIDTH  operand B register
- alu_result  in  DATA_BUS_WIDTH  alu result
- alu_flag  in  alu_flag_t  alu carry/zero
- rsp_valid  out  1  result valid (RESP only)
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  DATA_BUS_WIDTH  registered result
- flags  out  alu_flag_t  architectural flag register

Behaviour:
- Reset (synchronous, active-high): on clk edge with rst=1, all registers are cleared:
  - state=IDLE
  - op_q=NOP
  - a_q, b_q, result_q = 0
  - flags = {carry 0, zero 0}
- rst has priority over every other input and aborts any operation in any state; no response is produced for an aborted request.
- Op classes:
  - binary = ADD, SUB, AND, OR, XOR
  - unary = THR, SHL, ROL, SHR, ROR, NOT
  - NOP, plus any encoding not listed, is treated as NOP.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch op_q=req_op and clear b_q=0.
    - NOP: go to RESP with result_q=0; flags unchanged.
    - Otherwise: go to LOAD_A.
  - LOAD_A: bus_in_ready=1. On bus_in_valid, a_q=bus_in.
    - Binary: go to LOAD_B.
    - Unary: go to EXEC.
    - Without bus_in_valid: hold.
  - LOAD_B: bus_in_ready=1. On bus_in_valid, b_q=bus_in and go to EXEC; otherwise hold.
  - EXEC: one cycle. alu_op=op_q, alu_reg1=a_q, alu_reg2=b_q. Capture result_q=alu_result and flags=alu_flag, then go to RESP.
  - RESP: rsp_valid=1, rsp_result=result_q. On rsp_ready go to IDLE; otherwise hold with rsp_result and flags stable.
- Outside EXEC: alu_op=NOP; alu_reg1/alu_reg2 still show a_q/b_q.
- bus_in_ready is combinational from state only; it never depends on bus_in_valid.
- Minimum latency (request accepted at edge T, operands valid every cycle, rsp_ready=1):
  - unary: rsp_valid high in cycle T+3
  - binary: rsp_valid high in cycle T+4
  - NOP: rsp_valid high in cycle T+1
- Back-to-back: IDLE is always visited for one cycle between responses; req_ready=0 in every other state, and req_valid is ignored there.
- Flags:
  - Updated only in EXEC, and always from alu_flag, including for unary ops.
  - Persist across requests and through NOP.
  - Zero/carry semantics are those defined by the alu.
- Width: no arithmetic in this block. Carry comes solely from alu_flag.

Decomposition:
- controlpack (existing): alu_op_e and alu_flag_t.
- Add to controlpack:
  - seq_state_e {IDLE, LOAD_A, LOAD_B, EXEC, RESP}
  - an is_binary_op(alu_op_e) function for the op-class decode.
- No sub-module inside the sequencer. alu is instantiated beside it at the integration level, and together with it in the bench.

Test Plan:
- ADD with bus 0xF0 then 0x20, rsp_ready=1 -> rsp_valid at T+4, rsp_result=0x10, flags.carry=1, flags.zero=0.
- SUB with bus 0x05, 0x05 -> rsp_result=0x00, zero=1, carry=0. A following NOP -> rsp_result=0x00 at T+1; flags stay zero=1, carry=0.
- SHR with bus 0x01, bus_in_valid delayed 3 cycles -> LOAD_A holds with bus_in_ready=1; rsp_result=0x00, carry=1, zero=1; only one operand consumed.
- XOR 0xAA,0x55 with rsp_ready low 4 cycles -> rsp_valid held, rsp_result=0xFF stable; req_valid pulses during RESP are ignored (req_ready=0); IDLE is reached one cycle after rsp_ready.
- rst asserted in LOAD_B after a_q=0x33 -> next cycle state IDLE, req_ready=1, flags=0, alu_reg1=0x00, no rsp_valid.
- ROL 0x81 then immediate THR 0x00 -> first rsp_result=0x03 with carry=0; second rsp_result=0x00 with zero=1.
